// File: rtl/skin_bbox_detect.sv
// HSV skin-colour classifier producing a 0x00/0xFF mask stream and a per-frame
// bounding box / pixel count, published on each rising edge of vsync.
module skin_bbox_detect #(
  parameter logic [7:0] H_MIN   = 8'd240,
  parameter logic [7:0] H_MAX   = 8'd25,
  parameter logic [7:0] S_MIN   = 8'd40,
  parameter logic [7:0] S_MAX   = 8'd200,
  parameter logic [7:0] V_MIN   = 8'd60,
  parameter int         COORD_W = 11,
  parameter int         CNT_W   = 21
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic [7:0]         H,
  input  logic [7:0]         S,
  input  logic [7:0]         V,
  input  logic               in_hsync,
  input  logic               in_vsync,
  input  logic               in_de,
  output logic [7:0]         out_mask,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic               out_de,
  output logic [COORD_W-1:0] bbox_xmin,
  output logic [COORD_W-1:0] bbox_xmax,
  output logic [COORD_W-1:0] bbox_ymin,
  output logic [COORD_W-1:0] bbox_ymax,
  output logic [CNT_W-1:0]   pix_count,
  output logic               bbox_valid,
  output logic               frame_done
);

  localparam logic [COORD_W-1:0] COORD_ONES = {COORD_W{1'b1}};
  localparam logic [COORD_W-1:0] COORD_ZERO = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] COORD_ONE  = {{(COORD_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONES   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic               hue_ok_s, skin_s, vs_rise_s, de_fall_s;
  logic               vsync_d_r, de_d_r;
  logic [COORD_W-1:0] x_r, y_r;
  logic [COORD_W-1:0] acc_xmin_r, acc_xmax_r, acc_ymin_r, acc_ymax_r;
  logic [CNT_W-1:0]   acc_cnt_r;

  // Pixel classification; a wrapped hue window accepts either side of zero
  always_comb begin
    hue_ok_s = 1'b0;
    if (H_MIN <= H_MAX) begin
      hue_ok_s = (H >= H_MIN) && (H <= H_MAX);
    end else begin
      hue_ok_s = (H >= H_MIN) || (H <= H_MAX);
    end
  end

  assign skin_s    = in_de && hue_ok_s && (S >= S_MIN) && (S <= S_MAX) && (V >= V_MIN);
  assign vs_rise_s = ce && in_vsync && !vsync_d_r;
  assign de_fall_s = ce && !in_de && de_d_r;

  // Mask stream and delayed syncs, one ce-cycle behind the inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_mask  <= 8'h00;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_de    <= 1'b0;
      vsync_d_r <= 1'b0;
      de_d_r    <= 1'b0;
    end else if (ce) begin
      out_mask  <= skin_s ? 8'hFF : 8'h00;
      out_hsync <= in_hsync;
      out_vsync <= in_vsync;
      out_de    <= in_de;
      vsync_d_r <= in_vsync;
      de_d_r    <= in_de;
    end
  end

  // Column/row counters; frame start takes priority over end-of-line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r <= COORD_ZERO;
      y_r <= COORD_ZERO;
    end else if (vs_rise_s) begin
      x_r <= COORD_ZERO;
      y_r <= COORD_ZERO;
    end else if (de_fall_s) begin
      x_r <= COORD_ZERO;
      if (y_r != COORD_ONES) y_r <= y_r + COORD_ONE;
    end else if (ce && in_de && (x_r != COORD_ONES)) begin
      x_r <= x_r + COORD_ONE;
    end
  end

  // Running statistics; a skin pixel on the vsync-rise cycle seeds the new frame at (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_r  <= CNT_ZERO;
      acc_xmin_r <= COORD_ONES;
      acc_ymin_r <= COORD_ONES;
      acc_xmax_r <= COORD_ZERO;
      acc_ymax_r <= COORD_ZERO;
    end else if (vs_rise_s) begin
      acc_cnt_r  <= skin_s ? CNT_ONE : CNT_ZERO;
      acc_xmin_r <= skin_s ? COORD_ZERO : COORD_ONES;
      acc_ymin_r <= skin_s ? COORD_ZERO : COORD_ONES;
      acc_xmax_r <= COORD_ZERO;
      acc_ymax_r <= COORD_ZERO;
    end else if (ce && skin_s) begin
      if (acc_cnt_r != CNT_ONES) acc_cnt_r <= acc_cnt_r + CNT_ONE;
      if (x_r < acc_xmin_r) acc_xmin_r <= x_r;
      if (x_r > acc_xmax_r) acc_xmax_r <= x_r;
      if (y_r < acc_ymin_r) acc_ymin_r <= y_r;
      if (y_r > acc_ymax_r) acc_ymax_r <= y_r;
    end
  end

  // Published results and the frame_done strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bbox_xmin  <= COORD_ZERO;
      bbox_xmax  <= COORD_ZERO;
      bbox_ymin  <= COORD_ZERO;
      bbox_ymax  <= COORD_ZERO;
      pix_count  <= CNT_ZERO;
      bbox_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= vs_rise_s;
      if (vs_rise_s) begin
        bbox_xmin  <= acc_xmin_r;
        bbox_xmax  <= acc_xmax_r;
        bbox_ymin  <= acc_ymin_r;
        bbox_ymax  <= acc_ymax_r;
        pix_count  <= acc_cnt_r;
        bbox_valid <= (acc_cnt_r != CNT_ZERO);
      end
    end
  end

endmodule
